mod_addsub_arbiter: RTL and testbench

- Shares one secp256k1 modular add/subtract datapath among NUM_REQ requesters, such as point-add/double sequencers and the scalar-mult controller.
- Arbitrates round-robin, latches the granted operands, and computes (x ± y) mod P in a single registered stage.
- Returns the result with the requester ID over a valid/ready response channel.
- Sits between the ECC control FSMs and the field-arithmetic resources.

---
 rtl/mod_addsub_arbiter.sv | 115 +++++++++++
 tb/tb_mod_addsub_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_arbiter.sv
// Round-robin arbiter in front of one shared secp256k1 modular add/subtract stage.
// Valid/ready: a transfer happens on a rising edge where both valid and ready are high.
module mod_addsub_arbiter #(
  parameter int           NUM_REQ = 4,
  parameter int           ID_W    = 2,
  parameter logic [255:0] P       = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_op,
  input  logic [NUM_REQ*256-1:0] req_x,
  input  logic [NUM_REQ*256-1:0] req_y,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [255:0]           resp_data,
  output logic [ID_W-1:0]        resp_id,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_q;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand;
  logic [ID_W:0]   cand_sum;
  logic            found;
  logic [255:0]    x_q, y_q;
  logic            op_q;
  logic [256:0]    sum;
  logic [255:0]    diff;
  logic [255:0]    exec_res;

  // Search starts at rr_ptr and wraps modulo NUM_REQ (which need not be a power of two).
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    cand_sum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      cand = cand_sum[ID_W-1:0];
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && found) req_ready[gnt_idx] = 1'b1;
  end

  // Single correction step: exact for operands already reduced below P.
  always_comb begin
    sum  = {1'b0, x_q} + {1'b0, y_q};
    diff = x_q - y_q;
    if (!op_q) exec_res = (sum >= {1'b0, P}) ? (sum[255:0] - P) : sum[255:0];
    else       exec_res = (x_q < y_q) ? (diff + P) : diff;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      op_q      <= 1'b0;
      resp_data <= '0;
      resp_id   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (found) begin
          x_q   <= req_x[256*gnt_idx +: 256];
          y_q   <= req_y[256*gnt_idx +: 256];
          op_q  <= req_op[gnt_idx];
          gnt_q <= gnt_idx;
        end
        EXEC: begin
          resp_data <= exec_res;
          resp_id   <= gnt_q;
        end
        RESP: if (resp_ready) begin
          rr_ptr <= (gnt_q == ID_W'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mod_addsub_arbiter.sv
// Randomized and directed bench for mod_addsub_arbiter against an arithmetic reference model.
module tb_mod_addsub_arbiter;

  localparam int           NUM_REQ = 4;
  localparam int           ID_W    = 2;
  localparam logic [255:0] P       = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam int           W       = ID_W + 256;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     req_op = '0;
  logic [NUM_REQ*256-1:0] req_x = '0;
  logic [NUM_REQ*256-1:0] req_y = '0;
  logic                   resp_valid;
  logic                   resp_ready = 1'b0;
  logic [255:0]           resp_data;
  logic [ID_W-1:0]        resp_id;
  logic                   busy;

  mod_addsub_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .P(P)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard and reference state
  logic [W-1:0] exp_q[$];
  logic [255:0] tx[NUM_REQ];
  logic [255:0] ty[NUM_REQ];
  logic         top[NUM_REQ];
  int           ptr_m = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  function automatic logic [255:0] ref_mod(input logic op, input logic [255:0] x, input logic [255:0] y);
    logic [257:0] t;
    if (!op) t = ({2'b0, x} + {2'b0, y}) % {2'b0, P};
    else     t = ({2'b0, x} + {2'b0, P} - {2'b0, y}) % {2'b0, P};
    return t[255:0];
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < NUM_REQ; k++)
      if (req_valid[(ptr_m + k) % NUM_REQ]) return (ptr_m + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    int mode;
    mode = $urandom_range(0, 3);
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    if (mode == 0) r = 256'($urandom_range(0, 15));
    else if (mode == 1) r = P - 256'(1 + $urandom_range(0, 15));
    if (r >= P) r = r - P;
    return r;
  endfunction

  // driver tasks
  task automatic set_req(input int id, input logic op, input logic [255:0] x, input logic [255:0] y);
    tx[id] = x; ty[id] = y; top[id] = op;
    req_x[256*id +: 256] = x;
    req_y[256*id +: 256] = y;
    req_op[id]    = op;
    req_valid[id] = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
  endtask

  // Called at a negedge with requests set; returns at the negedge after the response handshake.
  task automatic transact(input int bp, input bit drop, input bit early_ready, input string tag);
    int g;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [W-1:0] e;
    #1;
    g = model_grant();
    exp_rdy = (g < 0) ? '0 : (NUM_REQ'(1) << g);
    n_checks++;
    if (req_ready !== exp_rdy) begin
      n_fail++; $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, exp_rdy);
    end
    if (g < 0) return;
    exp_q.push_back({ID_W'(g), ref_mod(top[g], tx[g], ty[g])});
    @(posedge clk);
    @(negedge clk);
    if (drop) req_valid[g] = 1'b0;
    if (early_ready) resp_ready = 1'b1;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== '0) begin
      n_fail++; $display("FAIL %s exec: resp_valid=%b busy=%b req_ready=%b expected 0 1 0", tag, resp_valid, busy, req_ready);
    end
    @(negedge clk); #1;
    e = exp_q.pop_front();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== e[255:0] || resp_id !== e[W-1:256]) begin
      n_fail++; $display("FAIL %s resp: valid=%b id=%0d data=%h expected 1 %0d %h", tag, resp_valid, resp_id, resp_data, e[W-1:256], e[255:0]);
    end
    for (int i = 0; i < bp; i++) begin
      resp_ready = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_data !== e[255:0] || resp_id !== e[W-1:256] || req_ready !== '0) begin
        n_fail++; $display("FAIL %s hold: valid=%b id=%0d data=%h req_ready=%b expected 1 %0d %h 0", tag, resp_valid, resp_id, resp_data, req_ready, e[W-1:256], e[255:0]);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    ptr_m = (g + 1) % NUM_REQ;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s after_hs: resp_valid=%b busy=%b expected 0 0", tag, resp_valid, busy);
    end
  endtask

  // scenarios
  task automatic test_reset();
    req_valid = 4'b1011;
    @(negedge clk); #1;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || resp_data !== '0 || resp_id !== '0) begin
      n_fail++; $display("FAIL reset_values: valid=%b busy=%b rdy=%b data=%h id=%0d expected all 0", resp_valid, busy, req_ready, resp_data, resp_id);
    end
    req_valid = '0;
    apply_reset();
  endtask

  task automatic test_directed();
    set_req(0, 1'b1, 256'd1, 256'd2);
    transact(0, 1, 0, "sub_wrap");
    set_req(1, 1'b0, P - 256'd1, 256'd2);
    transact(0, 1, 0, "add_reduce");
    set_req(1, 1'b0, P - 256'd1, 256'd1);
    transact(0, 1, 0, "add_to_zero");
    set_req(2, 1'b1, 256'h1234, 256'h1234);
    transact(0, 1, 1, "sub_equal_early_ready");
    set_req(3, 1'b1, 256'd5, 256'd3);
    transact(0, 1, 0, "sub_nowrap");
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 256'(i), 256'd0);
    for (int n = 0; n < 5; n++) transact(0, 0, 0, "rr_all");
    req_valid = 4'b0101;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL rr_ptr1_pick2: req_ready=%b expected 0100", req_ready);
    end
    transact(0, 1, 0, "rr_pick2");
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    set_req(3, 1'b0, rand256(), rand256());
    set_req(0, 1'b1, rand256(), rand256());
    set_req(2, 1'b0, rand256(), rand256());
    transact(5, 1, 0, "bp_first");
    transact(0, 1, 0, "bp_next");
    transact(2, 1, 0, "bp_last");
  endtask

  task automatic test_reset_mid_exec();
    int g;
    set_req(2, 1'b0, 256'd7, 256'd9);
    set_req(3, 1'b1, 256'd9, 256'd7);
    #1;
    g = model_grant();
    @(posedge clk);
    @(negedge clk);
    req_valid[g] = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_exec_busy: busy=%b expected 1", busy);
    end
    set_req(1, 1'b0, 256'd11, 256'd22);
    rst = 1'b1;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      n_fail++; $display("FAIL mid_exec_rst: valid=%b busy=%b rdy=%b expected 0 0 0", resp_valid, busy, req_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    transact(0, 1, 0, "post_rst_grant");
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), rand256(), rand256());
      if (req_valid == '0) set_req($urandom_range(0, NUM_REQ-1), 1'($urandom_range(0, 1)), rand256(), rand256());
      transact($urandom_range(0, 2), 1, 1'($urandom_range(0, 3) == 0), "random");
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
